// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants for the 800x480 LCD raster controller.
//   - Horizontal / vertical timing (sync, back porch, active, front porch)
//   - Derived totals H_TOTAL / V_TOTAL
//   - PIX_LAT: clocks from a coordinate request to the matching pix_data
//   - Bus widths COORD_W / RGB_W
//   - Colour-bar constants and bar_color() used when LCD_TEST_PATTERN_EN is defined
package lcd_pkg;

    localparam int H_SYNC  = 128;
    localparam int H_BACK  = 88;
    localparam int H_VALID = 800;
    localparam int H_FRONT = 40;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 33;
    localparam int V_VALID = 480;
    localparam int V_FRONT = 10;

    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam int PIX_LAT = 1;

    localparam int COORD_W = 11;
    localparam int RGB_W   = 24;

    localparam logic [RGB_W-1:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [RGB_W-1:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] BAR_RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] BAR_BLACK   = 24'h000000;

    // Eight 100-pixel-wide vertical bars; threshold compares avoid a divider.
    function automatic logic [RGB_W-1:0] bar_color(input logic [9:0] x);
        if (x < 10'd100)      return BAR_WHITE;
        else if (x < 10'd200) return BAR_YELLOW;
        else if (x < 10'd300) return BAR_CYAN;
        else if (x < 10'd400) return BAR_GREEN;
        else if (x < 10'd500) return BAR_MAGENTA;
        else if (x < 10'd600) return BAR_RED;
        else if (x < 10'd700) return BAR_BLUE;
        else                  return BAR_BLACK;
    endfunction

endpackage

// File: rtl/lcd_delay_pipe.sv
// lcd_delay_pipe: N-stage, W-bit register shift with synchronous active-high reset.
// Ports:
//   clk  in   clock
//   rst  in   synchronous reset, clears every stage
//   d    in   W-bit input
//   q    out  d delayed by N clocks
module lcd_delay_pipe #(
    parameter int N = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < N; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[N-1];

endmodule

// File: rtl/lcd_timing_ctrl.sv
// lcd_timing_ctrl: 800x480 LCD raster timing generator and panel output stage.
// Ports:
//   clk_in       in   pixel clock
//   sys_rst      in   synchronous active-high reset
//   pix_data     in   colour from the pixel generator, valid PIX_LAT clocks after its coordinates
//   test_sel     in   select the built-in colour-bar pattern (only with LCD_TEST_PATTERN_EN)
//   pix_x/pix_y  out  requested active-area coordinate, 0 outside the active area
//   pix_req      out  pix_x/pix_y are a valid request
//   lcd_hs/vs    out  active-high syncs, delayed to line up with lcd_de/lcd_rgb
//   lcd_de       out  data enable aligned to lcd_rgb
//   lcd_rgb      out  panel colour, 0 whenever lcd_de is low
//   frame_start  out  one-clock pulse for the raster origin (h_cnt=0, v_cnt=0)
// Build option: define LCD_TEST_PATTERN_EN to add the 8-bar test pattern on test_sel.
module lcd_timing_ctrl
    import lcd_pkg::*;
(
    input  logic               clk_in,
    input  logic               sys_rst,
    input  logic [RGB_W-1:0]   pix_data,
    input  logic               test_sel,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_req,
    output logic               lcd_hs,
    output logic               lcd_vs,
    output logic               lcd_de,
    output logic [RGB_W-1:0]   lcd_rgb,
    output logic               frame_start
);

    localparam logic [COORD_W-1:0] H_LAST      = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST      = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_FIRST = COORD_W'(H_SYNC + H_BACK);
    localparam logic [COORD_W-1:0] H_ACT_LAST  = COORD_W'(H_SYNC + H_BACK + H_VALID - 1);
    localparam logic [COORD_W-1:0] V_ACT_FIRST = COORD_W'(V_SYNC + V_BACK);
    localparam logic [COORD_W-1:0] V_ACT_LAST  = COORD_W'(V_SYNC + V_BACK + V_VALID - 1);
    localparam logic [COORD_W-1:0] H_SYNC_END  = COORD_W'(H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_END  = COORD_W'(V_SYNC);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_act;
    logic               v_act;
    logic               hs_raw;
    logic               vs_raw;
    logic               hs_d;
    logic               vs_d;
    logic               req_d;
    logic [RGB_W-1:0]   rgb_src;

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        h_act   = (h_cnt >= H_ACT_FIRST) && (h_cnt <= H_ACT_LAST);
        v_act   = (v_cnt >= V_ACT_FIRST) && (v_cnt <= V_ACT_LAST);
        pix_req = h_act && v_act;
        pix_x   = '0;
        pix_y   = '0;
        if (pix_req) begin
            pix_x = h_cnt - H_ACT_FIRST;
            pix_y = v_cnt - V_ACT_FIRST;
        end
        hs_raw = (h_cnt < H_SYNC_END);
        vs_raw = (v_cnt < V_SYNC_END);
    end

    // First PIX_LAT stages of the sync/DE pipe; the final stage is the
    // output register below so DE lands on the same edge as lcd_rgb.
    lcd_delay_pipe #(
        .N (PIX_LAT),
        .W (3)
    ) u_sync_pipe (
        .clk (clk_in),
        .rst (sys_rst),
        .d   ({hs_raw, vs_raw, pix_req}),
        .q   ({hs_d, vs_d, req_d})
    );

`ifdef LCD_TEST_PATTERN_EN
    logic [9:0] bar_x;

    // Bar colour follows the same latency as the generator's pix_data.
    lcd_delay_pipe #(
        .N (PIX_LAT),
        .W (10)
    ) u_bar_pipe (
        .clk (clk_in),
        .rst (sys_rst),
        .d   (pix_x[9:0]),
        .q   (bar_x)
    );

    assign rgb_src = test_sel ? bar_color(bar_x) : pix_data;
`else
    logic unused_test_sel;

    assign unused_test_sel = test_sel;
    assign rgb_src         = pix_data;
`endif

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            lcd_hs      <= 1'b0;
            lcd_vs      <= 1'b0;
            lcd_de      <= 1'b0;
            lcd_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            lcd_hs      <= hs_d;
            lcd_vs      <= vs_d;
            lcd_de      <= req_d;
            lcd_rgb     <= req_d ? rgb_src : '0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule
